// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates display reads and buffered compute writes onto the single-port SRAM controller
module sram_arbiter #(
    parameter int WR_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_Wr_Valid,
    input  logic [17:0] i_Wr_Addr,
    input  logic [15:0] i_Wr_Data,
    output logic        o_Wr_Ready,
    input  logic        i_Rd_Valid,
    input  logic [17:0] i_Rd_Addr,
    output logic        o_Rd_Ready,
    output logic        o_Rd_Valid,
    output logic [15:0] o_Rd_Data,
    output logic        o_Begin,
    output logic        o_Write,
    output logic [17:0] o_Addr,
    output logic [15:0] o_Data,
    input  logic        i_Ready,
    input  logic [15:0] i_Data
);
    localparam int AW = $clog2(WR_DEPTH);
    typedef enum logic [1:0] {ARB_IDLE, BUSY_RD, BUSY_WR} state_t;
    state_t        state;
    logic [33:0]   fifo [WR_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [17:0]   rd_addr;
    logic          rd_vld;
    logic [7:0]    streak;
    logic          wr_pend, push, issue, grant_wr, grant_rd;
    assign wr_pend    = count != '0;
    assign o_Wr_Ready = count != (AW+1)'(WR_DEPTH);
    assign o_Rd_Ready = !rd_vld;
    assign push       = i_Wr_Valid && o_Wr_Ready;
    assign issue      = state == ARB_IDLE && i_Ready && (rd_vld || wr_pend);
    // a pending write only overtakes a waiting read once the read streak hits the limit
    assign grant_wr   = issue && wr_pend && (!rd_vld || streak == 8'(STARVE_LIMIT));
    assign grant_rd   = issue && !grant_wr;
    assign o_Begin    = issue;
    assign o_Write    = grant_wr;
    assign o_Addr     = grant_wr ? fifo[rd_ptr][33:16] : grant_rd ? rd_addr : '0;
    assign o_Data     = grant_wr ? fifo[rd_ptr][15:0] : '0;
    always_ff @(posedge i_CLK)
        if (push) fifo[wr_ptr] <= {i_Wr_Addr, i_Wr_Data};
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state      <= ARB_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_addr    <= '0;
            rd_vld     <= 1'b0;
            streak     <= '0;
            o_Rd_Valid <= 1'b0;
            o_Rd_Data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (grant_wr) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(grant_wr);
            if (grant_rd) rd_vld <= 1'b0;
            else if (i_Rd_Valid && !rd_vld) begin
                rd_vld  <= 1'b1;
                rd_addr <= i_Rd_Addr;
            end
            if (!wr_pend || grant_wr) streak <= '0;
            else if (grant_rd && streak != 8'(STARVE_LIMIT)) streak <= streak + 8'd1;
            o_Rd_Valid <= 1'b0;
            case (state)
                ARB_IDLE: if (issue) state <= grant_wr ? BUSY_WR : BUSY_RD;
                BUSY_RD: if (i_Ready) begin
                    o_Rd_Data  <= i_Data;
                    o_Rd_Valid <= 1'b1;
                    state      <= ARB_IDLE;
                end
                BUSY_WR: if (i_Ready) state <= ARB_IDLE;
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-client front end for the single-port SRAM controller. Arbitrates between the display scan-out read client and the Julia compute write client, buffers compute writes in a small FIFO, and drives the controller's one-cycle Begin/Write request handshake. Sits directly upstream of the SRAM controller, whose o_Ready/o_Data_s2f it consumes.

## Interface
- WR_DEPTH, 4: write FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8: maximum consecutive read grants while a write is pending; range 1..255.

- i_CLK  in  1  system clock; all logic rising-edge.
- i_RST_N  in  1  reset, asynchronous assert, active-low.
- i_Wr_Valid  in  1  compute write request.
- i_Wr_Addr  in  18  write word address.
- i_Wr_Data  in  16  write data.
- o_Wr_Ready  out  1  FIFO not full; a push occurs when i_Wr_Valid & o_Wr_Ready.
- i_Rd_Valid  in  1  display read request.
- i_Rd_Addr  in  18  read word address.
- o_Rd_Ready  out  1  read holding register empty; accept on i_Rd_Valid & o_Rd_Ready.
- o_Rd_Valid  out  1  one-cycle pulse; o_Rd_Data valid.
- o_Rd_Data  out  16  returned read word.
- o_Begin  out  1  to controller i_Begin; one-cycle request strobe.
- o_Write  out  1  to controller i_Write.
- o_Addr  out  18  to controller i_Addr.
- o_Data  out  16  to controller i_Data_f2s.
- i_Ready  in  1  from controller o_Ready; high only when the controller is idle.
- i_Data  in  16  from controller o_Data_s2f.

## Operation
- Write FIFO: WR_DEPTH × 34 bits (addr, data), with count register; o_Wr_Ready = (count != WR_DEPTH). Pop happens in the write issue cycle. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo WR_DEPTH.
- Read holding register: single entry (addr plus valid flag); o_Rd_Ready = ~valid. It is cleared in the read issue cycle. A new read is accepted no earlier than the following cycle.
- FSM states:
  - ARB_IDLE: when i_Ready=1 and a request is pending, o_Begin=1 combinationally for that cycle, then go to BUSY_RD or BUSY_WR. If i_Ready=0, stay and issue nothing.
  - BUSY_RD: wait for i_Ready=1 (controller back to idle, data latched). On that cycle, register i_Data into o_Rd_Data, pulse o_Rd_Valid on the next cycle, and go to ARB_IDLE.
  - BUSY_WR: wait for i_Ready=1, then go to ARB_IDLE.
- No issue is made in a BUSY→ARB_IDLE cycle. The earliest next issue is the cycle after.
- Grant priority: read over write, except when streak == STARVE_LIMIT and the FIFO is non-empty; then the write wins.
  - streak (8 bits) increments on each read grant made while the FIFO is non-empty.
  - streak clears on any write grant and whenever the FIFO is empty.
  - streak saturates at STARVE_LIMIT.
- Controller outputs:
  - Read grant: o_Write=0, o_Addr=held addr, o_Data=0.
  - Write grant: o_Write=1, o_Addr/o_Data=FIFO head.
  - When o_Begin=0: o_Write, o_Addr and o_Data are all 0.
- Reset, asynchronous while i_RST_N=0:
  - FSM=ARB_IDLE; FIFO and holding register emptied; streak=0.
  - o_Begin=0, o_Write=0, o_Addr=0, o_Data=0, o_Rd_Valid=0, o_Rd_Data=0.
  - o_Wr_Ready=1, o_Rd_Ready=1.
  - Reset mid-transaction discards the in-flight read; no o_Rd_Valid follows.

## Timing
- The controller leaves idle the cycle after Begin (i_Ready low one cycle after issue). It holds its own reset state for one cycle after reset, with i_Ready low; the arbiter waits.
- Read: issue at T; controller idle again at T+3; o_Rd_Valid at T+4 with data. Next issue is possible at T+4.
- Write: issue at T; i_Ready returns at T+3; next issue is possible at T+4.
- Sustained throughput is one access per 4 cycles. o_Begin is never high on two consecutive cycles.
- Push-to-issue latency with an idle arbiter and empty FIFO: push at T, issue at T+1.

## Test plan
- Single write: push addr 0x00010/data 0xBEEF with idle controller model → o_Begin=1, o_Write=1, o_Addr=0x00010, o_Data=0xBEEF exactly one cycle later; FIFO empty afterwards.
- Single read: model returns 0x1234 at 0x3FFFF → o_Rd_Valid pulse one cycle wide, o_Rd_Data=0x1234, 4 cycles after issue.
- FIFO full: push 5 writes back-to-back while the controller is held busy → o_Wr_Ready=0 after the 4th; entries later issue in order; the 5th is accepted only after the first pop.
- Starvation: continuous reads with a write pending, STARVE_LIMIT=8 → exactly 8 read grants, then 1 write grant, then reads resume.
- Simultaneous arrival: read and write requests arrive in the same cycle with streak=0 → read issued first, write next.
- Reset mid-read: deassert i_RST_N during BUSY_RD → all outputs at reset values immediately; no o_Rd_Valid after release; first new request issues normally.
